// File: rtl/pipe_reg.sv
// pipe_reg: elastic valid/ready register pipeline with flush; define PIPE_REG_OCC_EN to add the occupancy output
module pipe_reg #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef PIPE_REG_OCC_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
`endif
);
  logic [DEPTH-1:0] r_valid;
  logic [WIDTH-1:0] r_data [DEPTH];
  logic [DEPTH-1:0] w_ready;
  logic [DEPTH-1:0] w_pvalid;
  logic [WIDTH-1:0] w_pdata [DEPTH];
  // ready ripples back from the output: a stage is ready when empty or its successor is ready
  always_comb begin
    logic acc;
    acc = out_ready;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      acc = ~r_valid[i] | acc;
      w_ready[i] = acc;
    end
    w_pvalid[0] = in_valid;
    w_pdata[0] = in_data;
    for (int i = 1; i < DEPTH; i++) begin
      w_pvalid[i] = r_valid[i-1];
      w_pdata[i] = r_data[i-1];
    end
  end
  // reset wipes everything, flush drops only valid bits, otherwise ready stages advance
  always_ff @(posedge clk)
    if (rst) begin
      r_valid <= '0;
      for (int i = 0; i < DEPTH; i++) r_data[i] <= '0;
    end else if (flush) r_valid <= '0;
    else
      for (int i = 0; i < DEPTH; i++)
        if (w_ready[i]) begin
          r_valid[i] <= w_pvalid[i];
          if (w_pvalid[i]) r_data[i] <= w_pdata[i];
        end
  assign in_ready = w_ready[0] & ~flush & ~rst;
  assign out_valid = r_valid[DEPTH-1] & ~flush & ~rst;
  assign out_data = r_data[DEPTH-1];
`ifdef PIPE_REG_OCC_EN
  localparam int OW = $clog2(DEPTH + 1);
  // popcount of stage valid bits, tracks the valid registers directly
  always_comb begin
    occupancy = '0;
    for (int i = 0; i < DEPTH; i++) occupancy = occupancy + OW'(r_valid[i]);
  end
`endif
endmodule

// File: tb/tb_pipe_reg.sv
// tb_pipe_reg: directed self-checking bench for pipe_reg (WIDTH=4, DEPTH=3)
module tb_pipe_reg;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic [3:0] in_data = 4'h0;
  logic in_ready, out_valid;
  logic [3:0] out_data;
  logic [1:0] occupancy;
  int n_cmp = 0;
  int n_err = 0;

  pipe_reg #(.WIDTH(4), .DEPTH(3)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
`ifdef PIPE_REG_OCC_EN
    , .occupancy(occupancy)
`endif
  );
`ifndef PIPE_REG_OCC_EN
  assign occupancy = 2'd0;
`endif

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b1; in_data = 4'hA; out_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst0_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL rst0_in_ready: got %b want 0", in_ready); end
    tick();
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst1_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (out_data !== 4'h0) begin n_err++; $display("FAIL rst1_out_data: got %h want 0", out_data); end
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL rst1_in_ready: got %b want 0", in_ready); end
`ifdef PIPE_REG_OCC_EN
    n_cmp++; if (occupancy !== 2'd0) begin n_err++; $display("FAIL rst1_occ: got %0d want 0", occupancy); end
`endif
    tick();
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_rel_in_ready: got %b want 1", in_ready); end
    n_cmp++; if (out_data !== 4'h0) begin n_err++; $display("FAIL rst_rel_out_data: got %h want 0", out_data); end
    tick();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_no_A c%0d: got out_valid %b want 0", c, out_valid); end
      tick();
    end
  endtask

  task automatic test_stream;
    out_ready = 1'b1;
    for (int c = 0; c < 13; c++) begin
      in_valid = (c < 10);
      in_data = 4'(c + 1);
      @(negedge clk);
      if (c < 10) begin
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL stream_in_ready c%0d: got %b want 1", c, in_ready); end
      end
      n_cmp++; if (out_valid !== (c >= 3)) begin n_err++; $display("FAIL stream_out_valid c%0d: got %b want %b", c, out_valid, c >= 3); end
      if (c >= 3) begin
        n_cmp++; if (out_data !== 4'(c - 2)) begin n_err++; $display("FAIL stream_out_data c%0d: got %0d want %0d", c, out_data, c - 2); end
      end
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic test_stall;
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      in_valid = 1'b1; in_data = 4'(5 + c);
      @(negedge clk);
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL stall_accept c%0d: got %b want 1", c, in_ready); end
      tick();
    end
    in_data = 4'h8;
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL stall_full_in_ready: got %b want 0", in_ready); end
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 4'h5) begin n_err++; $display("FAIL stall_head: got v=%b d=%0d want v=1 d=5", out_valid, out_data); end
`ifdef PIPE_REG_OCC_EN
    n_cmp++; if (occupancy !== 2'd3) begin n_err++; $display("FAIL stall_occ: got %0d want 3", occupancy); end
`endif
    tick();
    out_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL stall_pass_in_ready: got %b want 1", in_ready); end
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 4'h5) begin n_err++; $display("FAIL stall_out5: got v=%b d=%0d want v=1 d=5", out_valid, out_data); end
    tick();
    in_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_cmp++; if (out_valid !== 1'b1 || out_data !== 4'(6 + c)) begin n_err++; $display("FAIL stall_drain c%0d: got v=%b d=%0d want v=1 d=%0d", c, out_valid, out_data, 6 + c); end
      tick();
    end
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL stall_empty: got %b want 0", out_valid); end
    n_cmp++; if (out_data !== 4'h8) begin n_err++; $display("FAIL stall_hold_data: got %0d want 8", out_data); end
    tick();
  endtask

  task automatic test_bubble;
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 4'h1; tick();
    in_valid = 1'b0; tick();
    tick();
    in_valid = 1'b1; in_data = 4'h2;
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 4'h1) begin n_err++; $display("FAIL bubble_head: got v=%b d=%0d want v=1 d=1", out_valid, out_data); end
    tick();
    in_data = 4'h3;
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bubble_in_ready: got %b want 1", in_ready); end
`ifdef PIPE_REG_OCC_EN
    n_cmp++; if (occupancy !== 2'd2) begin n_err++; $display("FAIL bubble_occ2: got %0d want 2", occupancy); end
`endif
    tick();
    in_data = 4'h4;
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bubble_full: got %b want 0", in_ready); end
`ifdef PIPE_REG_OCC_EN
    n_cmp++; if (occupancy !== 2'd3) begin n_err++; $display("FAIL bubble_occ3: got %0d want 3", occupancy); end
`endif
    tick();
    in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_cmp++; if (out_valid !== 1'b1 || out_data !== 4'(1 + c)) begin n_err++; $display("FAIL bubble_drain c%0d: got v=%b d=%0d want v=1 d=%0d", c, out_valid, out_data, 1 + c); end
      tick();
    end
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bubble_empty: got %b want 0", out_valid); end
    tick();
  endtask

  task automatic test_flush;
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      in_valid = 1'b1; in_data = 4'(1 + c); tick();
    end
    flush = 1'b1; in_valid = 1'b1; in_data = 4'hF; out_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL flush_in_ready: got %b want 0", in_ready); end
    tick();
    flush = 1'b0; in_valid = 1'b1; in_data = 4'h3;
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_after_valid: got %b want 0", out_valid); end
    n_cmp++; if (out_data !== 4'h1) begin n_err++; $display("FAIL flush_data_kept: got %h want 1", out_data); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL flush_after_in_ready: got %b want 1", in_ready); end
`ifdef PIPE_REG_OCC_EN
    n_cmp++; if (occupancy !== 2'd0) begin n_err++; $display("FAIL flush_occ: got %0d want 0", occupancy); end
`endif
    tick();
    in_valid = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_gap c%0d: got %b want 0", c, out_valid); end
      tick();
    end
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 4'h3) begin n_err++; $display("FAIL flush_out3: got v=%b d=%h want v=1 d=3", out_valid, out_data); end
    tick();
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_end: got %b want 0", out_valid); end
    tick();
  endtask

  task automatic test_mid_reset;
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = 4'h9; tick();
    in_data = 4'hA; tick();
    rst = 1'b1; in_data = 4'hB;
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mrst_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL mrst_in_ready: got %b want 0", in_ready); end
    tick();
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (out_data !== 4'h0) begin n_err++; $display("FAIL mrst_out_data: got %h want 0", out_data); end
`ifdef PIPE_REG_OCC_EN
    n_cmp++; if (occupancy !== 2'd0) begin n_err++; $display("FAIL mrst_occ: got %0d want 0", occupancy); end
`endif
    tick();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mrst_ghost c%0d: got v=%b d=%h want v=0", c, out_valid, out_data); end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_bubble();
    test_flush();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
